mmio_job_afu: RTL
=================

MMIO_JOB_AFU -- requirements
Module: mmio_job_afu

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 64-bit per-process MMIO registers (power of two, >=4).
REQ-002 SHALL have parameter PARITY_EN, default 1; 1 = generate and check odd parity.
REQ-003 SHALL have one clock and an asynchronous active-low reset, ports listed first:
- clock  in  1  PSL clock (ha_pclock); all state on its rising edge.
- reset_n  in  1  asynchronous reset, active low.
REQ-004 SHALL have the MMIO ports:
- ha_mmval in 1; ha_mmcfg in 1; ha_mmrnw in 1; ha_mmdw in 1
- ha_mmad in [0:23]; ha_mmadpar in 1; ha_mmdata in [0:63]; ha_mmdatapar in 1
- ah_mmack out 1; ah_mmdata out [0:63]; ah_mmdatapar out 1
REQ-005 SHALL have the job ports:
- ha_jval in 1; ha_jcom in [0:7]; ha_jcompar in 1; ha_jea in [0:63]
- ah_jrunning out 1; ah_jdone out 1; ah_jerror out [0:63]
- ah_jcack out 1; ah_jyield out 1; ah_tbreq out 1; ah_paren out 1

Function
REQ-006 SHALL tie ah_jcack, ah_jyield and ah_tbreq to 0, and drive ah_paren = PARITY_EN.
REQ-007 SHALL implement job FSM states IDLE, RUNNING, DONE.
REQ-008 SHALL treat a command as accepted only when ha_jval=1 and (PARITY_EN=0 or ha_jcompar = odd parity of ha_jcom).
- A rejected command sets sticky error bit 62 and is otherwise ignored.
REQ-009 SHALL handle RESET (jcom 0x80) accepted at cycle N, from any state:
- ah_jdone=1 for cycle N+1 only; ah_jrunning=0 from N+1.
- State returns to IDLE.
- All registers and sticky errors clear.
- ah_jerror=0 during that jdone pulse.
REQ-010 SHALL handle START (jcom 0x90) accepted at cycle N in IDLE:
- WED register latches ha_jea; cycle counter clears.
- ah_jrunning=1 from N+1; state RUNNING.
- START in RUNNING or DONE is ignored.
REQ-011 SHALL handle, in RUNNING, an accepted write at cycle N to reg 0 with bit 63 = 1:
- State DONE at N+1; ah_jrunning=0 from N+1.
- ah_jdone=1 for cycle N+1 only.
- ah_jerror = sticky error bits during that cycle, 0 at all other times.
REQ-012 SHALL give priority to RESET when a RESET and a done-write coincide.
REQ-013 SHALL acknowledge every MMIO access with exactly one ah_mmack cycle at N+1, ah_mmdata valid in that same cycle.
- Also applies during RESET handling.
- Accesses are never back-to-back with less than one idle cycle.
REQ-014 SHALL handle config-space reads (ha_mmcfg=1):
- Doubleword index 0 returns 0x0000_0001_0001_8010.
- Other indices return 0.
- Config-space writes are acked and dropped.
REQ-015 SHALL map per-process registers by doubleword index ha_mmad[23-log2(NUM_REGS):22]:
- Reg 0: control, RW, bit 63 = done strobe, reads back 0.
- Reg 1: WED, read-only.
- Reg 2: cycle counter, read-only, +1 per RUNNING cycle, wraps modulo 2^64.
- Regs 3..NUM_REGS-1: scratch, RW.
- Any higher address bits nonzero: reads 0, writes dropped.
REQ-016 SHALL handle 32-bit accesses (ha_mmdw=0):
- ha_mmad[23]=0 selects bits [0:31]; 1 selects bits [32:63].
- Writes take ha_mmdata[32:63] into the selected half only.
- Reads return the selected half replicated in both halves.
REQ-017 SHALL drop an MMIO write with bad ha_mmadpar or ha_mmdatapar (PARITY_EN=1), still ack it, and set sticky error bit 63.
REQ-018 SHALL drive ah_mmdatapar = odd parity of ah_mmdata when PARITY_EN=1, else 0.

Reset
REQ-019 SHALL, while reset_n=0, force:
- ah_mmack, ah_jrunning, ah_jdone = 0
- ah_mmdata, ah_jerror = 0
- All registers and sticky bits = 0; FSM = IDLE.
REQ-020 SHALL drop any MMIO access in flight when reset_n asserts, with no ack.

Structure
REQ-021 SHALL take the following from shared package afu_pkg:
- job command codes, FSM state enum, register indices
- descriptor constant, odd-parity function
REQ-022 SHALL place register storage and read mux in one sub-module, afu_mmio_regs.

Verification
REQ-023 SHALL cover: START jea=0x1234 at N; read reg1 -> jrunning=1 at N+1; mmdata=0x1234, mmack at the read cycle +1.
REQ-024 SHALL cover: write reg3=0xDEADBEEF_CAFEF00D; 32-bit read addr bit23=1 -> mmdata=0xCAFEF00D_CAFEF00D, correct mmdatapar.
REQ-025 SHALL cover: write with bad ha_mmdatapar, then done-write -> reg unchanged; jdone pulse with jerror bit 63 = 1.
REQ-026 SHALL cover: RESET coinciding with done-write while RUNNING -> single jdone, jerror=0, reg3 reads 0.
REQ-027 SHALL cover: config read index 0 -> 0x0000000100018010; reg2 read after 10 RUNNING cycles -> value >= 10.
REQ-028 SHALL cover: reset_n pulsed mid-access -> no mmack, all outputs 0.

Source files
------------

// File: rtl/afu_pkg.sv
// Shared definitions for the PSL job/MMIO accelerator function unit.
// Latency: n/a (types, constants and a parity helper only).
// Backpressure: n/a.
package afu_pkg;

    // Job control command codes seen on ha_jcom.
    localparam logic [7:0] CMD_RESET = 8'h80;
    localparam logic [7:0] CMD_START = 8'h90;

    // Job state machine.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } job_state_t;

    // Per-process register doubleword indices.
    localparam int REG_CTRL     = 0;
    localparam int REG_WED      = 1;
    localparam int REG_CNT      = 2;
    localparam int REG_SCRATCH0 = 3;

    // AFU descriptor returned at config-space doubleword 0.
    localparam logic [63:0] AFU_DESC = 64'h0000_0001_0001_8010;

    // Odd parity: the returned bit makes the total count of ones odd.
    // Narrower operands are zero-extended by the caller, which does not
    // change the XOR reduction.
    function automatic logic odd_parity(input logic [63:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/afu_mmio_regs.sv
// Per-process register file: WED, RUNNING-cycle counter, scratch regs, read mux.
// Latency: writes land on the next rising edge; the read mux is combinational.
// Backpressure: none, every write strobe is taken in the cycle it is presented.
//
// Ports: clock/reset_n; clr (synchronous clear of all state); wed_load/wed_in;
// cnt_clr/cnt_inc; wr_en/wr_full/wr_lo/wr_idx/wr_data (write port, 32-bit
// writes carry their payload in wr_data[32:63]); rd_idx -> rd_data.
module afu_mmio_regs
    import afu_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic                        wed_load,
    input  logic [0:63]                 wed_in,
    input  logic                        cnt_clr,
    input  logic                        cnt_inc,
    input  logic                        wr_en,
    input  logic                        wr_full,
    input  logic                        wr_lo,
    input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
    input  logic [0:63]                 wr_data,
    input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
    output logic [0:63]                 rd_data
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [0:63] wed;
    logic [0:63] cnt;
    // Entries below REG_SCRATCH0 are never written and are trimmed away.
    logic [0:63] scratch [NUM_REGS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wed <= '0;
            cnt <= '0;
            for (int i = 0; i < NUM_REGS; i++) scratch[i] <= '0;
        end else if (clr) begin
            wed <= '0;
            cnt <= '0;
            for (int i = 0; i < NUM_REGS; i++) scratch[i] <= '0;
        end else begin
            if (wed_load) wed <= wed_in;

            // Counter wraps naturally at 2^64.
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 64'd1;

            // Control, WED and counter are not writable storage.
            if (wr_en && (wr_idx >= IDX_W'(REG_SCRATCH0))) begin
                if (wr_full)    scratch[wr_idx]        <= wr_data;
                else if (wr_lo) scratch[wr_idx][32:63] <= wr_data[32:63];
                else            scratch[wr_idx][0:31]  <= wr_data[32:63];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_idx)
            IDX_W'(REG_CTRL): rd_data = '0;   // done strobe is write-only
            IDX_W'(REG_WED):  rd_data = wed;
            IDX_W'(REG_CNT):  rd_data = cnt;
            default:          rd_data = scratch[rd_idx];
        endcase
    end

endmodule

// File: rtl/mmio_job_afu.sv
// PSL accelerator function unit: job FSM (IDLE/RUNNING/DONE) plus MMIO slave.
// Latency: every MMIO access is acked with data exactly one cycle after ha_mmval.
// Backpressure: none; the PSL guarantees an idle cycle between MMIO accesses.
//
// Ports: clock/reset_n; MMIO request ha_mm* and response ah_mmack/ah_mmdata/
// ah_mmdatapar; job command ha_jval/ha_jcom/ha_jcompar/ha_jea and status
// ah_jrunning/ah_jdone/ah_jerror; constant ah_jcack/ah_jyield/ah_tbreq/ah_paren.
// Vectors use PSL big-endian numbering: bit 0 is the MSB.
module mmio_job_afu
    import afu_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int PARITY_EN = 1
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        ha_mmval,
    input  logic        ha_mmcfg,
    input  logic        ha_mmrnw,
    input  logic        ha_mmdw,
    input  logic [0:23] ha_mmad,
    input  logic        ha_mmadpar,
    input  logic [0:63] ha_mmdata,
    input  logic        ha_mmdatapar,
    output logic        ah_mmack,
    output logic [0:63] ah_mmdata,
    output logic        ah_mmdatapar,

    input  logic        ha_jval,
    input  logic [0:7]  ha_jcom,
    input  logic        ha_jcompar,
    input  logic [0:63] ha_jea,
    output logic        ah_jrunning,
    output logic        ah_jdone,
    output logic [0:63] ah_jerror,
    output logic        ah_jcack,
    output logic        ah_jyield,
    output logic        ah_tbreq,
    output logic        ah_paren
);

    localparam int   IDX_W  = $clog2(NUM_REGS);
    localparam logic PAR_EN = (PARITY_EN != 0);

    assign ah_jcack  = 1'b0;
    assign ah_jyield = 1'b0;
    assign ah_tbreq  = 1'b0;
    assign ah_paren  = PAR_EN;

    job_state_t state;
    logic       err_cmd;   // sticky: rejected job command (bit 62)
    logic       err_par;   // sticky: dropped MMIO write on parity (bit 63)

    // ---------------- job command decode ----------------
    logic cmd_par_ok, cmd_ok, cmd_rej, do_reset, do_start;
    assign cmd_par_ok = !PAR_EN || (ha_jcompar == odd_parity({56'b0, ha_jcom}));
    assign cmd_ok     = ha_jval && cmd_par_ok;
    assign cmd_rej    = ha_jval && !cmd_par_ok;
    assign do_reset   = cmd_ok && (ha_jcom == CMD_RESET);
    assign do_start   = cmd_ok && (ha_jcom == CMD_START) && (state == ST_IDLE);

    // ---------------- MMIO decode ----------------
    logic [IDX_W-1:0] mm_idx;
    logic             hi_zero, cfg_idx0, mm_par_ok, mm_wr, wr_bad, wr_ok;
    logic             done_bit, do_done;

    assign mm_idx    = ha_mmad[23-IDX_W:22];
    assign hi_zero   = (ha_mmad[0:22-IDX_W] == '0);
    assign cfg_idx0  = (ha_mmad[0:22] == '0);
    assign mm_par_ok = !PAR_EN ||
                       ((ha_mmadpar   == odd_parity({40'b0, ha_mmad})) &&
                        (ha_mmdatapar == odd_parity(ha_mmdata)));
    assign mm_wr     = ha_mmval && !ha_mmrnw;
    assign wr_bad    = mm_wr && !mm_par_ok;
    // A RESET in the same cycle wins over any register write.
    assign wr_ok     = mm_wr && mm_par_ok && !ha_mmcfg && hi_zero && !do_reset;

    // Bit 63 of the written value: a 32-bit write only reaches it through the
    // low half (ha_mmad[23]=1), which takes ha_mmdata[32:63] unshifted.
    assign done_bit  = ha_mmdata[63] && (ha_mmdw || ha_mmad[23]);
    assign do_done   = wr_ok && (mm_idx == IDX_W'(REG_CTRL)) && done_bit &&
                       (state == ST_RUNNING);

    logic err_cmd_nxt, err_par_nxt;
    assign err_cmd_nxt = !do_reset && (err_cmd || cmd_rej);
    assign err_par_nxt = !do_reset && (err_par || wr_bad);

    // ---------------- register file ----------------
    logic [0:63] reg_rd;

    afu_mmio_regs #(.NUM_REGS(NUM_REGS)) u_regs (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (do_reset),
        .wed_load (do_start),
        .wed_in   (ha_jea),
        .cnt_clr  (do_start),
        .cnt_inc  (state == ST_RUNNING),
        .wr_en    (wr_ok),
        .wr_full  (ha_mmdw),
        .wr_lo    (ha_mmad[23]),
        .wr_idx   (mm_idx),
        .wr_data  (ha_mmdata),
        .rd_idx   (mm_idx),
        .rd_data  (reg_rd)
    );

    // ---------------- read data path ----------------
    logic [0:63] rd_base, rd_sel, rd_nxt;

    always_comb begin
        rd_base = '0;
        if (ha_mmcfg) begin
            if (cfg_idx0) rd_base = AFU_DESC;
        end else if (hi_zero) begin
            rd_base = reg_rd;
        end

        // 32-bit reads replicate the addressed half into both halves.
        if (ha_mmdw)          rd_sel = rd_base;
        else if (ha_mmad[23]) rd_sel = {rd_base[32:63], rd_base[32:63]};
        else                  rd_sel = {rd_base[0:31],  rd_base[0:31]};

        rd_nxt = (ha_mmval && ha_mmrnw) ? rd_sel : '0;
    end

    // ---------------- FSM and registered outputs ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            err_cmd      <= 1'b0;
            err_par      <= 1'b0;
            ah_jrunning  <= 1'b0;
            ah_jdone     <= 1'b0;
            ah_jerror    <= '0;
            ah_mmack     <= 1'b0;
            ah_mmdata    <= '0;
            ah_mmdatapar <= 1'b0;
        end else begin
            ah_mmack     <= ha_mmval;
            ah_mmdata    <= rd_nxt;
            ah_mmdatapar <= PAR_EN && odd_parity(rd_nxt);

            err_cmd      <= err_cmd_nxt;
            err_par      <= err_par_nxt;

            // jdone/jerror are single-cycle pulses by default.
            ah_jdone     <= 1'b0;
            ah_jerror    <= '0;

            if (do_reset) begin
                state       <= ST_IDLE;
                ah_jrunning <= 1'b0;
                ah_jdone    <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (do_start) begin
                            state       <= ST_RUNNING;
                            ah_jrunning <= 1'b1;
                        end
                    end
                    ST_RUNNING: begin
                        if (do_done) begin
                            state       <= ST_DONE;
                            ah_jrunning <= 1'b0;
                            ah_jdone    <= 1'b1;
                            ah_jerror   <= {62'b0, err_cmd_nxt, err_par_nxt};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
